// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss
// Minutes:seconds BCD countdown timer (up to 99:59) driven by a 1 s timebase.
// A small FSM (IDLE/RUN/PAUSE/EXPIRED) handles load/start/pause/clear.
// All outputs are registered; reset is synchronous active-low.
module countdown_timer_mmss #(
  parameter bit TICK_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       tick_q;
  logic       running_q, done_q, done_d, alarm_q, load_err_q, load_err_d;
  logic       tick_ev_s;
  logic [15:0] dec_s;

  // A preset is legal when every digit is 0-9 and seconds tens is 0-5.
  function automatic logic bcd_load_valid(input logic [7:0] m, input logic [7:0] s);
    bcd_load_valid = (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9) &&
                     (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
  endfunction

  // One-second BCD decrement of {min, sec}; the caller never passes 00:00.
  function automatic logic [15:0] bcd_mmss_dec(input logic [15:0] mmss);
    logic [7:0] m;
    logic [7:0] s;
    m = mmss[15:8];
    s = mmss[7:0];
    if (s[3:0] != 4'd0) begin
      s[3:0] = s[3:0] - 4'd1;
    end else if (s[7:4] != 4'd0) begin
      s = {s[7:4] - 4'd1, 4'd9};
    end else begin
      s = 8'h59;
      if (m[3:0] != 4'd0) begin
        m[3:0] = m[3:0] - 4'd1;
      end else begin
        m = {m[7:4] - 4'd1, 4'd9};
      end
    end
    bcd_mmss_dec = {m, s};
  endfunction

  // Tick history register used for rising-edge qualification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  // Tick event: rising edge of a square wave, or the raw one-clk enable.
  always_comb begin
    if (TICK_EDGE) begin
      tick_ev_s = tick & ~tick_q;
    end else begin
      tick_ev_s = tick;
    end
  end

  // Next-state logic: clear > load > start/pause > tick; a tick coinciding
  // with any accepted action or state change is dropped.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    dec_s      = bcd_mmss_dec({min_q, sec_q});
    if (clear) begin
      state_d = ST_IDLE;
      min_d   = 8'h00;
      sec_d   = 8'h00;
    end else if (load && (state_q != ST_RUN)) begin
      if (bcd_load_valid(load_min, load_sec)) begin
        state_d = ST_IDLE;
        min_d   = load_min;
        sec_d   = load_sec;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_ev_s) begin
            min_d = dec_s[15:8];
            sec_d = dec_s[7:0];
            if (dec_s == 16'h0000) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start && ({min_q, sec_q} != 16'h0000)) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      running_q  <= (state_d == ST_RUN);
      done_q     <= done_d;
      alarm_q    <= (state_d == ST_EXPIRED);
      load_err_q <= load_err_d;
    end
  end

  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign running  = running_q;
  assign done     = done_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Self-checking bench for countdown_timer_mmss: directed scenarios followed by
// randomized control/tick traffic, compared every cycle against a model that
// keeps the count as a plain number of seconds.
module tb_countdown_timer_mmss;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // Reference model state
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_st = M_IDLE;
  int m_cnt = 0;
  bit m_tick_prev = 1'b0;
  bit m_done = 1'b0;
  bit m_lerr = 1'b0;

  countdown_timer_mmss #(.TICK_EDGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start),
    .pause(pause), .clear(clear), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .running(running), .done(done), .alarm(alarm), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int max_tens);
    bcd_ok = (int'(b / 8'd16) <= max_tens) && (int'(b % 8'd16) <= 9);
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    bcd_val = int'(b / 8'd16) * 10 + int'(b % 8'd16);
  endfunction

  // Model of one clock edge, using the inputs the DUT sampled at that edge.
  task automatic model_step();
    bit ev;
    bit moved;
    m_done = 1'b0;
    m_lerr = 1'b0;
    if (!rst_n) begin
      m_st = M_IDLE; m_cnt = 0; m_tick_prev = 1'b0;
    end else begin
      ev = tick && !m_tick_prev;
      m_tick_prev = tick;
      if (clear) begin
        m_st = M_IDLE; m_cnt = 0;
      end else if (load && m_st != M_RUN) begin
        if (bcd_ok(load_min, 9) && bcd_ok(load_sec, 5)) begin
          m_cnt = bcd_val(load_min) * 60 + bcd_val(load_sec);
          m_st = M_IDLE;
        end else begin
          m_lerr = 1'b1;
        end
      end else begin
        moved = 1'b0;
        if (m_st == M_RUN && pause) begin
          m_st = M_PAUSE; moved = 1'b1;
        end else if ((m_st == M_PAUSE || m_st == M_IDLE) && start && m_cnt != 0) begin
          m_st = M_RUN; moved = 1'b1;
        end
        if (!moved && m_st == M_RUN && ev) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_st = M_EXP; m_done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      if (done === 1'b1) done_seen++;
      chk("min", min_bcd, to_bcd(m_cnt / 60));
      chk("sec", sec_bcd, to_bcd(m_cnt % 60));
      chk("running", running, (m_st == M_RUN));
      chk("alarm", alarm, (m_st == M_EXP));
      chk("done", done, m_done);
      chk("load_err", load_err, m_lerr);
    end
  endtask

  task automatic quiet();
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load_min = m; load_sec = s; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(1); pause = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(5); tick = 1'b0; step(2);
  endtask

  int tick_left;
  int r;
  int k;

  initial begin
    rst_n = 1'b0; tick = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    quiet();

    // Reset with tick toggling and start pulsed
    step(1);
    tick = 1'b1; start = 1'b1; step(1);
    tick = 1'b0; start = 1'b0; step(1);
    chk("rst_count", {min_bcd, sec_bcd}, 16'h0000);
    chk("rst_flags", {running, done, alarm, load_err}, 4'b0000);
    rst_n = 1'b1; step(2);

    // Countdown to expiry
    do_load(8'h00, 8'h03);
    do_start();
    done_seen = 0;
    do_tick(); chk("cd_02", {min_bcd, sec_bcd}, 16'h0002);
    do_tick(); chk("cd_01", {min_bcd, sec_bcd}, 16'h0001);
    do_tick(); chk("cd_00", {min_bcd, sec_bcd}, 16'h0000);
    chk("cd_alarm", alarm, 1'b1);
    chk("cd_done_once", done_seen, 1);
    do_tick(); chk("cd_hold", {min_bcd, sec_bcd}, 16'h0000);
    chk("cd_done_once_after", done_seen, 1);

    // Borrow across minutes
    do_load(8'h10, 8'h00); do_start(); do_tick();
    chk("borrow_0959", {min_bcd, sec_bcd}, 16'h0959);
    do_pause(); do_load(8'h01, 8'h00); do_start(); do_tick();
    chk("borrow_0059", {min_bcd, sec_bcd}, 16'h0059);

    // Pause / resume
    clear = 1'b1; step(1); clear = 1'b0;
    do_load(8'h00, 8'h10); do_start(); do_tick();
    chk("pr_09", {min_bcd, sec_bcd}, 16'h0009);
    do_pause();
    for (int i = 0; i < 4; i++) do_tick();
    chk("pr_hold", {min_bcd, sec_bcd}, 16'h0009);
    do_start(); do_tick();
    chk("pr_08", {min_bcd, sec_bcd}, 16'h0008);
    start = 1'b1; pause = 1'b1; step(1); quiet();
    chk("sp_to_pause", running, 1'b0);

    // Load rules
    do_load(8'h00, 8'h6A);
    chk("bad_load_err", load_err, 1'b1);
    chk("bad_load_cnt", {min_bcd, sec_bcd}, 16'h0008);
    do_start();
    do_load(8'h00, 8'h30);
    chk("run_load_noerr", load_err, 1'b0);
    chk("run_load_cnt", {min_bcd, sec_bcd}, 16'h0008);
    clear = 1'b1; step(1); clear = 1'b0;
    done_seen = 0;
    do_load(8'h00, 8'h00); do_start();
    chk("zero_start", running, 1'b0);
    do_tick();
    chk("zero_no_done", done_seen, 0);

    // Priority: clear + load + tick edge while running at 05:00
    do_load(8'h05, 8'h00); do_start();
    done_seen = 0;
    clear = 1'b1; load_min = 8'h01; load_sec = 8'h00; load = 1'b1; tick = 1'b1;
    step(1); quiet();
    chk("prio_cnt", {min_bcd, sec_bcd}, 16'h0000);
    chk("prio_run", running, 1'b0);
    step(4); tick = 1'b0; step(1);
    chk("prio_no_done", done_seen, 0);

    // Reset mid-run at 00:01
    do_load(8'h00, 8'h02); do_start(); do_tick();
    chk("mr_01", {min_bcd, sec_bcd}, 16'h0001);
    done_seen = 0;
    rst_n = 1'b0; tick = 1'b1; step(1);
    chk("mr_cnt", {min_bcd, sec_bcd}, 16'h0000);
    chk("mr_run", running, 1'b0);
    rst_n = 1'b1; step(4); tick = 1'b0; step(2); do_tick();
    chk("mr_no_done", done_seen, 0);

    // Randomized traffic against the model
    tick_left = 1;
    for (int i = 0; i < 5000; i++) begin
      quiet();
      rst_n = ($urandom_range(0, 399) != 0);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        clear = 1'b1;
      end else if (r < 8) begin
        load = 1'b1;
        k = $urandom_range(0, 3);
        case (k)
          0: begin load_min = 8'h00; load_sec = to_bcd($urandom_range(1, 9)); end
          1: begin load_min = to_bcd($urandom_range(0, 2)); load_sec = to_bcd($urandom_range(0, 59)); end
          2: begin load_min = 8'($urandom); load_sec = 8'($urandom); end
          default: begin load_min = 8'h00; load_sec = 8'h00; end
        endcase
      end else if (r < 16) begin
        start = 1'b1;
      end else if (r < 20) begin
        pause = 1'b1;
      end else if (r < 22) begin
        start = 1'b1; pause = 1'b1;
      end
      tick_left--;
      if (tick_left <= 0) begin
        tick = ~tick;
        tick_left = $urandom_range(1, 6);
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer_mmss.md
Name: countdown_timer_mmss

Overview:
- Downstream consumer of the 1 s timebase in the MatlabEd timing chain.
- Implements a minutes:seconds countdown timer (up to 99:59) in BCD for direct 7-segment drive.
- Decrements once per 1 s tick and raises done/alarm at 00:00.
- User controls: load, start, pause and clear from debounced buttons/switches; timer state held in a small FSM.

Parameters:
- TICK_EDGE, 1, 1 = tick input is a level/square wave and the block counts its rising edges; 0 = tick is already a one-clk-wide enable.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- tick  input  1  1 s timebase; square wave or pulse, synchronous to clk.
- load  input  1  load preset value (one-clk pulse).
- load_min  input  8  preset minutes, BCD, {tens, units}.
- load_sec  input  8  preset seconds, BCD, {tens, units}.
- start  input  1  start/resume (one-clk pulse).
- pause  input  1  pause (one-clk pulse).
- clear  input  1  clear to 00:00 and IDLE (one-clk pulse).
- min_bcd  output  8  current minutes, BCD.
- sec_bcd  output  8  current seconds, BCD.
- running  output  1  high while in RUN.
- done  output  1  one-clk pulse on reaching 00:00.
- alarm  output  1  high while in EXPIRED.
- load_err  output  1  one-clk pulse when a load is rejected.

Behaviour:
- Reset, when rst_n=0 at posedge clk: min_bcd=00, sec_bcd=00, state=IDLE, running=0, done=0, alarm=0, load_err=0, tick history reg=0. Reset wins over every other input, including mid-RUN.
- Tick qualification:
  - TICK_EDGE=1: tick_ev = tick & ~tick_q, where tick_q is tick registered.
  - TICK_EDGE=0: tick_ev = tick.
  - A tick held high for many cycles yields exactly one event.
- States:
  - IDLE: count holds.
  - RUN: counts down on tick_ev.
  - PAUSE: count holds.
  - EXPIRED: count=00:00, alarm=1.
- Input priority per cycle: clear > load > start/pause > tick_ev.
- clear: any state -> IDLE; count := 00:00; alarm := 0.
- load:
  - Accepted in IDLE, PAUSE or EXPIRED. Ignored in RUN, with no load_err.
  - Valid value: every nibble <= 9 and the seconds tens nibble <= 5. Valid load sets the count and moves to IDLE.
  - Invalid value: count and state unchanged; load_err=1 for one cycle.
- start:
  - IDLE/PAUSE with count != 00:00 -> RUN.
  - IDLE/PAUSE with count == 00:00 -> no change.
  - Ignored in RUN and EXPIRED.
- pause: RUN -> PAUSE. Ignored elsewhere.
- start and pause in the same cycle:
  - In RUN: -> PAUSE.
  - In PAUSE: -> RUN.
- A tick_ev in the same cycle as an accepted clear, load or state change is discarded.
- Decrement, in RUN on tick_ev, at the same clk edge where tick_q captures the rise:
  - sec units > 0: decrement sec units.
  - else sec tens > 0: sec units := 9, decrement sec tens.
  - else (sec = 00): sec := 59 and the minutes borrow; min units wraps 0 -> 9 with a tens decrement.
- Expiry: when the decrement result is 00:00, at that same edge: state := EXPIRED, done=1 for exactly one cycle, alarm=1, running=0.
- EXPIRED holds until clear or a valid load. Further ticks have no effect; no underflow past 00:00.
- running is a registered state decode; it goes high the cycle after start is sampled.

Test Plan:
- Reset: rst_n=0 for 3 cycles with tick toggling and start pulsed -> all outputs 0, min/sec=00:00.
- Countdown: load 00:03, start, 3 tick rising edges (tick high 5 cycles each) -> 00:02, 00:01, 00:00. done pulses once, for 1 cycle, at the third edge; alarm stays 1; a 4th tick leaves 00:00.
- Borrow: load 10:00, start, 1 tick -> 09:59. Load 01:00, 1 tick -> 00:59.
- Pause/resume: load 00:10, start, tick -> 00:09; pause, 4 ticks -> stays 00:09; start, tick -> 00:08. Start+pause together in RUN -> PAUSE.
- Load rules: load sec=8'h6A -> load_err pulse, count unchanged. Load during RUN -> ignored, no load_err. Load 00:00 then start -> stays IDLE, no done.
- Priority: clear+load+tick in the same cycle during RUN at 05:00 -> IDLE, 00:00, no done. rst_n=0 mid-RUN at 00:01 -> 00:00, IDLE, done never asserted.
